// File: rtl/axi_mm_mem_responder.sv
// axi_mm_mem_responder: AXI4 responder over a DEPTH x DATA_WIDTH array with independent write/read burst engines.
// Define AXI_MM_RESP_RANGE_CHK_EN to drop/zero out-of-range beats with SLVERR instead of wrapping modulo DEPTH.
module axi_mm_mem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_awvalid_i,
  output logic                    s_awready_o,
  input  logic [ID_WIDTH-1:0]     s_awid_i,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
  input  logic [7:0]              s_awlen_i,
  input  logic [2:0]              s_awsize_i,
  input  logic [1:0]              s_awburst_i,
  input  logic [USER_WIDTH-1:0]   s_awuser_i,
  input  logic                    s_wvalid_i,
  output logic                    s_wready_o,
  input  logic [DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
  input  logic                    s_wlast_i,
  output logic                    s_bvalid_o,
  input  logic                    s_bready_i,
  output logic [ID_WIDTH-1:0]     s_bid_o,
  output logic [1:0]              s_bresp_o,
  output logic [USER_WIDTH-1:0]   s_buser_o,
  input  logic                    s_arvalid_i,
  output logic                    s_arready_o,
  input  logic [ID_WIDTH-1:0]     s_arid_i,
  input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
  input  logic [7:0]              s_arlen_i,
  input  logic [1:0]              s_arburst_i,
  input  logic [USER_WIDTH-1:0]   s_aruser_i,
  output logic                    s_rvalid_o,
  input  logic                    s_rready_i,
  output logic [ID_WIDTH-1:0]     s_rid_o,
  output logic [DATA_WIDTH-1:0]   s_rdata_o,
  output logic [1:0]              s_rresp_o,
  output logic                    s_rlast_o,
  output logic [USER_WIDTH-1:0]   s_ruser_o
);
  localparam int STRB = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRB);
`ifdef AXI_MM_RESP_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  function automatic logic burst_bad(input logic [1:0] b, input logic [7:0] len);
    return b == 2'd3 || (b == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction
  function automatic logic [1:0] burst_eff(input logic [1:0] b, input logic [7:0] len);
    return burst_bad(b, len) ? 2'd1 : b;
  endfunction
  // legal wrap lengths are 2^k-1, so the window mask is just len with the byte-lane bits set
  function automatic logic [ADDR_WIDTH-1:0] nxt_addr(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                                     input logic [1:0] b);
    logic [ADDR_WIDTH-1:0] m;
    m = ADDR_WIDTH'({len, {ADDR_LSB{1'b1}}});
    return b == 2'd0 ? a : b == 2'd2 ? (a & ~m) | ((a + STEP) & m) : a + STEP;
  endfunction
  function automatic logic oor(input logic [ADDR_WIDTH-1:0] a);
    return RANGE_CHK && (a >> ADDR_LSB) >= ADDR_WIDTH'(DEPTH);
  endfunction
  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_LSB +: IDX_W];
  endfunction
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  wstate_t               wst_q;
  logic                  awready_q, wready_q, bvalid_q, werr_q;
  logic [1:0]            bresp_q, wburst_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [USER_WIDTH-1:0] buser_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q, wcnt_q;
  rstate_t               rst_q;
  logic                  arready_q, rvalid_q, rlast_q, rerr_q;
  logic [1:0]            rresp_q, rburst_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [USER_WIDTH-1:0] ruser_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q, rcnt_q;
  logic                  aw_hs, w_hs, ar_hs, werr_d, rerr_d;
  logic [ADDR_WIDTH-1:0] raddr_d, rd_addr;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  unused;
  assign unused  = ^s_awsize_i;
  assign aw_hs   = s_awvalid_i && awready_q;
  assign w_hs    = s_wvalid_i && wready_q;
  assign ar_hs   = s_arvalid_i && arready_q;
  assign werr_d  = werr_q | (s_wlast_i != (wcnt_q == 8'd0)) | oor(waddr_q);
  assign raddr_d = nxt_addr(raddr_q, rlen_q, rburst_q);
  assign rd_addr = rst_q == R_IDLE ? s_araddr_i : raddr_d;
  assign rdata_d = oor(rd_addr) ? '0 : mem_q[idx(rd_addr)];
  assign rerr_d  = (rst_q == R_IDLE ? burst_bad(s_arburst_i, s_arlen_i) : rerr_q) | oor(rd_addr);
  always_ff @(posedge clk)
    if (w_hs && !oor(waddr_q))
      for (int b = 0; b < STRB; b++)
        if (s_wstrb_i[b]) mem_q[idx(waddr_q)][8*b +: 8] <= s_wdata_i[8*b +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'd0;
      bid_q     <= '0;
      buser_q   <= '0;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wcnt_q    <= 8'd0;
      wburst_q  <= 2'd0;
      werr_q    <= 1'b0;
    end else begin
      case (wst_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s_awid_i;
            buser_q   <= s_awuser_i;
            waddr_q   <= s_awaddr_i;
            wlen_q    <= s_awlen_i;
            wcnt_q    <= s_awlen_i;
            wburst_q  <= burst_eff(s_awburst_i, s_awlen_i);
            werr_q    <= burst_bad(s_awburst_i, s_awlen_i);
            wst_q     <= W_DATA;
          end
        end
        W_DATA:
          if (w_hs) begin
            waddr_q <= nxt_addr(waddr_q, wlen_q, wburst_q);
            wcnt_q  <= wcnt_q - 8'd1;
            werr_q  <= werr_d;
            if (wcnt_q == 8'd0) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= {werr_d, 1'b0};
              wst_q    <= W_RESP;
            end
          end
        default:
          if (s_bready_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wst_q     <= W_IDLE;
          end
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'd0;
      rdata_q   <= '0;
      rid_q     <= '0;
      ruser_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rcnt_q    <= 8'd0;
      rburst_q  <= 2'd0;
      rerr_q    <= 1'b0;
    end else begin
      case (rst_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= s_arid_i;
            ruser_q   <= s_aruser_i;
            raddr_q   <= s_araddr_i;
            rlen_q    <= s_arlen_i;
            rcnt_q    <= 8'd0;
            rburst_q  <= burst_eff(s_arburst_i, s_arlen_i);
            rerr_q    <= burst_bad(s_arburst_i, s_arlen_i);
            rlast_q   <= s_arlen_i == 8'd0;
            rdata_q   <= rdata_d;
            rresp_q   <= {rerr_d, 1'b0};
            rst_q     <= R_DATA;
          end
        end
        default:
          if (rvalid_q && s_rready_i) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rst_q     <= R_IDLE;
            end else begin
              raddr_q <= raddr_d;
              rcnt_q  <= rcnt_q + 8'd1;
              rlast_q <= rcnt_q + 8'd1 == rlen_q;
              rdata_q <= rdata_d;
              rresp_q <= {rerr_d, 1'b0};
            end
          end
      endcase
    end
  assign s_awready_o = awready_q;
  assign s_wready_o  = wready_q;
  assign s_bvalid_o  = bvalid_q;
  assign s_bid_o     = bid_q;
  assign s_bresp_o   = bresp_q;
  assign s_buser_o   = buser_q;
  assign s_arready_o = arready_q;
  assign s_rvalid_o  = rvalid_q;
  assign s_rid_o     = rid_q;
  assign s_rdata_o   = rdata_q;
  assign s_rresp_o   = rresp_q;
  assign s_rlast_o   = rlast_q;
  assign s_ruser_o   = ruser_q;
endmodule

// File: tb/tb_axi_mm_mem_responder.sv
// tb_axi_mm_mem_responder: directed vector table plus burst sequences for axi_mm_mem_responder.
module tb_axi_mm_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_awvalid = 0, s_awready;
  logic [3:0]  s_awid = 0;
  logic [15:0] s_awaddr = 0;
  logic [7:0]  s_awlen = 0;
  logic [2:0]  s_awsize = 3'd3;
  logic [1:0]  s_awburst = 0;
  logic [0:0]  s_awuser = 0;
  logic        s_wvalid = 0, s_wready;
  logic [63:0] s_wdata = 0;
  logic [7:0]  s_wstrb = 0;
  logic        s_wlast = 0;
  logic        s_bvalid, s_bready = 0;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic [0:0]  s_buser;
  logic        s_arvalid = 0, s_arready;
  logic [3:0]  s_arid = 0;
  logic [15:0] s_araddr = 0;
  logic [7:0]  s_arlen = 0;
  logic [1:0]  s_arburst = 0;
  logic [0:0]  s_aruser = 0;
  logic        s_rvalid, s_rready = 0;
  logic [3:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [0:0]  s_ruser;
  int          tests = 0, fails = 0;
  logic [63:0] rd_d [16];
  logic [1:0]  rd_r [16];
  logic [1:0]  wr_bresp;
  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    logic [63:0] e;
  } vec_t;
  vec_t v [7];
  always #5 clk = ~clk;
  axi_mm_mem_responder dut (
    .clk(clk), .rst(rst),
    .s_awvalid_i(s_awvalid), .s_awready_o(s_awready), .s_awid_i(s_awid), .s_awaddr_i(s_awaddr),
    .s_awlen_i(s_awlen), .s_awsize_i(s_awsize), .s_awburst_i(s_awburst), .s_awuser_i(s_awuser),
    .s_wvalid_i(s_wvalid), .s_wready_o(s_wready), .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wlast_i(s_wlast),
    .s_bvalid_o(s_bvalid), .s_bready_i(s_bready), .s_bid_o(s_bid), .s_bresp_o(s_bresp), .s_buser_o(s_buser),
    .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_arid_i(s_arid), .s_araddr_i(s_araddr),
    .s_arlen_i(s_arlen), .s_arburst_i(s_arburst), .s_aruser_i(s_aruser),
    .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rid_o(s_rid), .s_rdata_o(s_rdata),
    .s_rresp_o(s_rresp), .s_rlast_o(s_rlast), .s_ruser_o(s_ruser)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", n, a, e);
    end
  endtask
  task automatic wr(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [3:0] id,
                    input logic [63:0] base, input logic [7:0] strb, input int lastbeat);
    int n;
    s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awid = id; s_awuser = id[0]; s_awvalid = 1'b1;
    n = 0;
    while (!s_awready && n < 50) begin @(posedge clk); #1; n++; end
    chk("aw_ready", s_awready, 1);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1'b1; s_wdata = base + 64'(i); s_wstrb = strb; s_wlast = (i == lastbeat);
      n = 0;
      while (!s_wready && n < 50) begin @(posedge clk); #1; n++; end
      chk("w_ready", s_wready, 1);
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk("b_latency", s_bvalid, 1);
    wr_bresp = s_bresp;
    chk("b_id", s_bid, id);
    chk("b_user", s_buser, id[0]);
    repeat (2) begin @(posedge clk); #1; end
    chk("b_hold", {s_bvalid, s_bresp}, {1'b1, wr_bresp});
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    chk("b_drop", {s_bvalid, s_awready}, 2'b01);
  endtask
  task automatic rd(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [3:0] id,
                    input logic [15:0] smask, input int sn);
    int n;
    logic [63:0] d0;
    logic [3:0]  c0;
    s_araddr = addr; s_arlen = len; s_arburst = burst; s_arid = id; s_aruser = ~id[0]; s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ar_ready", s_arready, 1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    chk("r_latency", s_rvalid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (smask[i]) begin
        s_rready = 1'b0;
        d0 = s_rdata; c0 = {s_rvalid, s_rlast, s_rresp};
        repeat (sn) begin
          @(posedge clk); #1;
          chk("r_hold_data", s_rdata, d0);
          chk("r_hold_ctl", {s_rvalid, s_rlast, s_rresp}, c0);
        end
      end
      chk("r_valid", s_rvalid, 1);
      chk("r_last", s_rlast, i == int'(len));
      chk("r_id", {s_rid, s_ruser}, {id, ~id[0]});
      rd_d[i] = s_rdata; rd_r[i] = s_rresp;
      s_rready = 1'b1;
      @(posedge clk); #1;
    end
    s_rready = 1'b0;
    chk("r_done", {s_rvalid, s_arready}, 2'b01);
  endtask
  initial begin
    v[0] = '{16'h0008, 64'h1122334455667788, 8'hFF, 64'h1122334455667788};
    v[1] = '{16'h0008, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h11223344FFFFFFFF};
    v[2] = '{16'h000C, 64'h0000000000000000, 8'hF0, 64'h00000000FFFFFFFF};
    v[3] = '{16'h0010, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'hDEADBEEFCAFEF00D};
    v[4] = '{16'h0010, 64'h0000000000000000, 8'h00, 64'hDEADBEEFCAFEF00D};
    v[5] = '{16'h0010, 64'h00AA00AA00AA00AA, 8'h55, 64'hDEAABEAACAAAF0AA};
    v[6] = '{16'h07F8, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF};
    #1 rst = 1'b1;
    #1;
    chk("rst_ctl", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast, s_bresp, s_rresp}, 0);
    chk("rst_data", {s_rdata}, 0);
    chk("rst_ids", {s_bid, s_rid}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {s_awready, s_arready, s_wready}, 3'b110);
    for (int k = 0; k < 7; k++) begin
      wr(v[k].a, 8'd0, 2'd1, 4'(k), v[k].d, v[k].s, 0);
      chk("vec_bresp", wr_bresp, 0);
      rd(v[k].a, 8'd0, 2'd1, 4'(k + 8), 16'h0, 0);
      chk("vec_data", rd_d[0], v[k].e);
      chk("vec_rresp", rd_r[0], 0);
    end
    wr(16'h0040, 8'd3, 2'd1, 4'h3, 64'hA0, 8'hFF, 3);
    chk("incr_bresp", wr_bresp, 0);
    rd(16'h0040, 8'd3, 2'd1, 4'h5, 16'h0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("incr_data", rd_d[i], 64'hA0 + 64'(i));
      chk("incr_rresp", rd_r[i], 0);
    end
    wr(16'h0000, 8'd3, 2'd1, 4'h1, 64'h50, 8'hFF, 3);
    rd(16'h0018, 8'd3, 2'd2, 4'h2, 16'h0, 0);
    chk("wrap_b0", rd_d[0], 64'h53);
    chk("wrap_b1", rd_d[1], 64'h50);
    chk("wrap_b2", rd_d[2], 64'h51);
    chk("wrap_b3", rd_d[3], 64'h52);
    chk("wrap_rresp", {rd_r[0], rd_r[3]}, 0);
    wr(16'h0000, 8'd2, 2'd0, 4'h4, 64'h1, 8'hFF, 2);
    chk("fixed_bresp", wr_bresp, 0);
    rd(16'h0000, 8'd1, 2'd1, 4'h6, 16'h0, 0);
    chk("fixed_w0", rd_d[0], 64'h3);
    chk("fixed_w1", rd_d[1], 64'h51);
    wr(16'h0400, 8'd1, 2'd1, 4'h6, 64'hB0, 8'hFF, 0);
    chk("wlast_early_bresp", wr_bresp, 2);
    rd(16'h0400, 8'd1, 2'd1, 4'h7, 16'h0002, 5);
    chk("wlast_early_b0", rd_d[0], 64'hB0);
    chk("wlast_early_b1", rd_d[1], 64'hB1);
    wr(16'h0300, 8'd1, 2'd3, 4'h9, 64'hE0, 8'hFF, 1);
    chk("rsvd_burst_bresp", wr_bresp, 2);
    rd(16'h0300, 8'd1, 2'd1, 4'hA, 16'h0, 0);
    chk("rsvd_burst_data", {rd_d[0][7:0], rd_d[1][7:0]}, 16'hE0E1);
    rd(16'h0000, 8'd2, 2'd2, 4'hB, 16'h0, 0);
    chk("bad_wrap_data", {rd_d[0][7:0], rd_d[1][7:0], rd_d[2][7:0]}, 24'h035152);
    chk("bad_wrap_rresp", {rd_r[0], rd_r[1], rd_r[2]}, 6'b101010);
    wr(16'h0200, 8'd7, 2'd1, 4'hC, 64'h70, 8'hFF, 7);
    fork
      wr(16'h0100, 8'd7, 2'd1, 4'h2, 64'hC0, 8'hFF, 7);
      rd(16'h0200, 8'd7, 2'd1, 4'h4, 16'h00AA, 1);
    join
    chk("conc_bresp", wr_bresp, 0);
    for (int i = 0; i < 8; i++) chk("conc_rd", rd_d[i], 64'h70 + 64'(i));
    rd(16'h0100, 8'd7, 2'd1, 4'hD, 16'h0, 0);
    for (int i = 0; i < 8; i++) chk("conc_wr", rd_d[i], 64'hC0 + 64'(i));
    rd(16'h07F8, 8'd1, 2'd1, 4'hE, 16'h0, 0);
    chk("edge_b0", rd_d[0], 64'h0123456789ABCDEF);
    chk("edge_b0_resp", rd_r[0], 0);
`ifdef AXI_MM_RESP_RANGE_CHK_EN
    chk("edge_b1", rd_d[1], 64'h0);
    chk("edge_b1_resp", rd_r[1], 2);
`else
    chk("edge_b1", rd_d[1], 64'h3);
    chk("edge_b1_resp", rd_r[1], 0);
`endif
    s_araddr = 16'h0200; s_arlen = 8'd7; s_arburst = 2'd1; s_arid = 4'hF; s_arvalid = 1'b1;
    for (int n = 0; n < 50 && !s_arready; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    chk("mid_rd_valid", s_rvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_async", {s_rvalid, s_rlast, s_arready, s_rresp}, 0);
    chk("mid_rst_rdata", s_rdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {s_arready, s_awready, s_rvalid}, 3'b110);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_mm_mem_responder.md
Name: axi_mm_mem_responder

Overview:
- AXI4 memory-mapped subordinate (responder) that terminates the manager side of an AXI-MM link, for example the output of a pipeline bridge.
- Backs a DEPTH x DATA_WIDTH register array.
- Independent write and read engines support INCR, FIXED and WRAP bursts.
- Used as a bench/loopback target and as a small scratchpad in FIM subsystems.

Parameters:
DATA_WIDTH, 64, data bus width in bits; power of 2, range 32..512
ADDR_WIDTH, 16, byte address width
ID_WIDTH, 4, AWID/ARID width
USER_WIDTH, 1, awuser/aruser width, echoed on buser/ruser
DEPTH, 256, number of words; power of 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_awvalid/s_awready  in/out  1  write address handshake
s_awid  in  ID_WIDTH  write ID
s_awaddr  in  ADDR_WIDTH  write start byte address
s_awlen  in  8  beats-1
s_awsize  in  3  ignored; full-width beats required
s_awburst  in  2  0 FIXED, 1 INCR, 2 WRAP
s_awuser  in  USER_WIDTH  write user
s_wvalid/s_wready  in/out  1  write data handshake
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  byte enables
s_wlast  in  1  last beat marker
s_bvalid/s_bready  out/in  1  write response handshake
s_bid  out  ID_WIDTH  = captured awid
s_bresp  out  2  0 OKAY, 2 SLVERR
s_buser  out  USER_WIDTH  = captured awuser
s_arvalid/s_arready  in/out  1  read address handshake
s_arid, s_araddr, s_arlen, s_arburst, s_aruser  in  as AW equivalents
s_rvalid/s_rready  out/in  1  read data handshake
s_rid  out  ID_WIDTH  = captured arid
s_rdata  out  DATA_WIDTH  read data
s_rresp  out  2  OKAY/SLVERR
s_rlast  out  1  final beat
s_ruser  out  USER_WIDTH  = captured aruser

Behaviour:
- Reset (rst=1, asynchronous): all outputs 0 (awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, rdata, bid, rid). Memory contents are not reset. The first cycle after reset release drives awready=arready=1.
- Word index = addr[ADDR_LSB +: log2(DEPTH)], where ADDR_LSB = log2(DATA_WIDTH/8). Low address bits are ignored.
- Address step per beat:
  - INCR: +DATA_WIDTH/8.
  - FIXED: +0.
  - WRAP: wraps within a (len+1)*bytes aligned window; only len 1,3,7,15 are legal. Illegal WRAP lengths are treated as INCR and return SLVERR.
- awburst=3 (reserved) is treated as INCR with SLVERR.
- Write FSM:
  - W_IDLE (awready=1): AW handshake captures id/addr/len/burst/user, sets beat count = awlen, goes to W_DATA.
  - W_DATA (wready=1): each W handshake writes the enabled bytes per wstrb and decrements the count. The burst ends on count 0, not on wlast.
  - wlast must be 1 on the final beat and 0 otherwise. Any mismatch makes bresp SLVERR; data is still written.
  - After the final beat, go to W_RESP.
  - W_RESP: bvalid=1, held with stable bid/bresp/buser until bready; then back to W_IDLE.
  - Latency: last W handshake at cycle N gives bvalid at N+1.
- Read FSM:
  - R_IDLE (arready=1): AR handshake captures fields, goes to R_DATA.
  - R_DATA: rvalid=1 with rdata = mem[index]. rdata, rid, rresp and rlast stay stable while rready=0. Each R handshake advances the address; rlast=1 on beat arlen.
  - After the final handshake, return to R_IDLE; arready reasserts on the next cycle.
  - Latency: AR handshake at N gives first rvalid at N+1. Back-to-back beats are allowed (one per cycle while rready=1).
- Read and write engines run concurrently. If a write and a read hit the same word in the same cycle, the read beat launched that cycle returns the pre-write value. The next read beat sees the new value.
- Only one outstanding transaction per direction; no interleaving; no write-data-before-address (wready=0 in W_IDLE).
- Reset asserted mid-burst aborts all bursts immediately. Partially written words remain written.

Optional Feature:
- Macro AXI_MM_RESP_RANGE_CHK_EN.
- Defined: any beat whose byte address >> ADDR_LSB >= DEPTH is out of range.
  - Out-of-range writes are dropped and force bresp=SLVERR.
  - Out-of-range reads return rdata=0, rresp=SLVERR for that beat.
  - In-range beats of the same burst behave normally.
- Undefined: the index is address modulo DEPTH and no range SLVERR is generated. Protocol-error SLVERRs (wlast mismatch, illegal burst) remain.

Test Plan:
1. INCR write addr 0x0040, len=3, data 0xA0..0xA3, wstrb all-ones, wlast on beat 3 -> bvalid one cycle after last beat, bresp=0, bid=awid. Then INCR read same address, len=3 -> rdata 0xA0..0xA3, rlast only on 4th beat, rresp=0.
2. Write 0x1122334455667788 to 0x0008, then write 0xFF..FF with wstrb=0x0F -> read returns 0x11223344FFFFFFFF.
3. WRAP read addr 0x0018, len=3 (64-bit bus) -> beats from word indices 3,0,1,2. Next, FIXED write len=2 to 0x0000 with 1,2,3 -> readback of word 0 = 3.
4. Write len=1 with wlast=1 on beat 0 -> bresp=2, both beats written. rready held low 5 cycles during a read -> rdata/rlast stable, no beat lost.
5. Concurrent: write burst to 0x0100 while reading 0x0200 len=7 with rready toggling -> both complete, data correct. Assert rst mid-read -> rvalid=0 asynchronously, arready=1 after release.
6. With AXI_MM_RESP_RANGE_CHK_EN, DEPTH=256: INCR read at 0x07F8 len=1 -> beat0 OKAY with data, beat1 rdata=0 rresp=2. Without the macro, beat1 returns word 0 with OKAY.
